// File: rtl/ifetch_icache_pkg.sv
// Shared widths, cache geometry defaults and fetch FSM state type for ifetch_icache.
package ifetch_icache_pkg;

  localparam int AddrLen = 32;
  localparam int InstLen = 32;
  localparam logic [31:0] ZERO_WORD = '0;
  localparam logic True  = 1'b1;
  localparam logic False = 1'b0;

  localparam int ICACHE_INDEX_BITS = 8;
  localparam int ICACHE_TAG_BITS   = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MISS = 1'b1
  } ifetch_state_e;

  function automatic logic [AddrLen-1:0] word_align(input logic [AddrLen-1:0] a);
    return {a[AddrLen-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_icache_way.sv
// One way of the instruction cache: tag/data/valid arrays with an asynchronous
// read port and a synchronous write port. Only the valid bits are reset.
module icache_way
  import ifetch_icache_pkg::*;
#(
  parameter int INDEX_BITS = ICACHE_INDEX_BITS,
  parameter int TAG_BITS   = ICACHE_TAG_BITS
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [INDEX_BITS-1:0] i_rd_index,
  output logic                  o_rd_valid,
  output logic [TAG_BITS-1:0]   o_rd_tag,
  output logic [InstLen-1:0]    o_rd_data,
  input  logic                  i_we,
  input  logic [INDEX_BITS-1:0] i_wr_index,
  input  logic [TAG_BITS-1:0]   i_wr_tag,
  input  logic [InstLen-1:0]    i_wr_data
);

  localparam int Sets = 2 ** INDEX_BITS;

  logic [Sets-1:0]     r_valid;
  logic [TAG_BITS-1:0] r_tag  [Sets];
  logic [InstLen-1:0]  r_data [Sets];

  always_ff @(posedge i_clk) begin
    if (i_rst)     r_valid <= '0;
    else if (i_we) r_valid[i_wr_index] <= 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_tag[i_wr_index]  <= i_wr_tag;
      r_data[i_wr_index] <= i_wr_data;
    end
  end

  assign o_rd_valid = r_valid[i_rd_index];
  assign o_rd_tag   = r_tag[i_rd_index];
  assign o_rd_data  = r_data[i_rd_index];

endmodule

// File: rtl/ifetch_icache.sv
// Instruction fetch stage with a direct-mapped or 2-way instruction cache and a
// miss/refill FSM. Define IFETCH_ICACHE_PERF_EN to add hit_cnt/miss_cnt outputs.
module ifetch_icache
  import ifetch_icache_pkg::*;
#(
  parameter int INDEX_BITS = ICACHE_INDEX_BITS,
  parameter int TAG_BITS   = ICACHE_TAG_BITS,
  parameter int WAYS       = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic [AddrLen-1:0] pc_i,
  input  logic               pc_valid,
  input  logic               jump_or_not,
  output logic [AddrLen-1:0] pc_o,
  output logic [InstLen-1:0] inst_o,
  output logic               inst_valid,
  output logic               if_stall,
  output logic [AddrLen-1:0] mem_addr,
  output logic               mem_req,
  input  logic [InstLen-1:0] mem_inst,
  input  logic               mem_done
`ifdef IFETCH_ICACHE_PERF_EN
  ,
  output logic [31:0]        hit_cnt,
  output logic [31:0]        miss_cnt
`endif
);

  ifetch_state_e       r_state, w_state_nxt;
  logic [AddrLen-1:0]  r_pc_o, w_pc_o_nxt;
  logic [InstLen-1:0]  r_inst_o, w_inst_o_nxt;
  logic                r_inst_valid, w_inst_valid_nxt;
  logic [AddrLen-1:0]  r_mem_addr, w_mem_addr_nxt;
  logic                r_mem_req, w_mem_req_nxt;
  logic [AddrLen-1:0]  r_miss_pc, w_miss_pc_nxt;
  logic                w_fill, w_hit_deliver, w_hit, w_victim;

  logic [INDEX_BITS-1:0] w_rd_index;
  logic [TAG_BITS-1:0]   w_rd_tag;
  logic [WAYS-1:0]       w_way_valid, w_way_match, w_way_we;
  logic [TAG_BITS-1:0]   w_way_tag  [WAYS];
  logic [InstLen-1:0]    w_way_data [WAYS];
  logic [InstLen-1:0]    w_hit_data;

  // The single lookup port serves the incoming pc in IDLE and the refill line in MISS.
  assign w_rd_index = (r_state == ST_MISS) ? r_miss_pc[INDEX_BITS+1:2] : pc_i[INDEX_BITS+1:2];
  assign w_rd_tag   = (r_state == ST_MISS) ? r_miss_pc[INDEX_BITS+2 +: TAG_BITS]
                                           : pc_i[INDEX_BITS+2 +: TAG_BITS];

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    icache_way #(
      .INDEX_BITS(INDEX_BITS),
      .TAG_BITS  (TAG_BITS)
    ) u_way (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_rd_index(w_rd_index),
      .o_rd_valid(w_way_valid[g]),
      .o_rd_tag  (w_way_tag[g]),
      .o_rd_data (w_way_data[g]),
      .i_we      (w_way_we[g]),
      .i_wr_index(w_rd_index),
      .i_wr_tag  (w_rd_tag),
      .i_wr_data (mem_inst)
    );
    assign w_way_match[g] = w_way_valid[g] && (w_way_tag[g] == w_rd_tag);
    assign w_way_we[g]    = rdy && w_fill && (int'(w_victim) == g);
  end

  always_comb begin
    w_hit_data = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (w_way_match[w]) w_hit_data = w_way_data[w];
    end
  end
  assign w_hit = |w_way_match;

  if (WAYS == 2) begin : g_lru
    // r_lru[set] names the way to evict next.
    logic [2**INDEX_BITS-1:0] r_lru;
    always_comb begin
      if (!w_way_valid[0])      w_victim = 1'b0;
      else if (!w_way_valid[1]) w_victim = 1'b1;
      else                      w_victim = r_lru[w_rd_index];
    end
    always_ff @(posedge clk) begin
      if (rst) r_lru <= '0;
      else if (rdy) begin
        if (w_hit_deliver) r_lru[w_rd_index] <= ~w_way_match[1];
        else if (w_fill)   r_lru[w_rd_index] <= ~w_victim;
      end
    end
  end else if (WAYS == 1) begin : g_direct
    assign w_victim = 1'b0;
  end else begin : g_bad
    $error("ifetch_icache: WAYS must be 1 or 2");
  end

  if (INDEX_BITS + TAG_BITS + 2 > AddrLen) begin : g_bad_geom
    $error("ifetch_icache: INDEX_BITS + TAG_BITS exceeds the pc width");
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_o_nxt       = r_pc_o;
    w_inst_o_nxt     = r_inst_o;
    w_inst_valid_nxt = False;
    w_mem_req_nxt    = r_mem_req;
    w_mem_addr_nxt   = r_mem_addr;
    w_miss_pc_nxt    = r_miss_pc;
    w_fill           = False;
    w_hit_deliver    = False;
    if (jump_or_not) begin
      // A refill landing on the flush cycle still fills the line, but is not delivered.
      w_state_nxt   = ST_IDLE;
      w_mem_req_nxt = False;
      w_fill        = (r_state == ST_MISS) && mem_done;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (pc_valid) begin
            if (w_hit) begin
              w_pc_o_nxt       = pc_i;
              w_inst_o_nxt     = w_hit_data;
              w_inst_valid_nxt = True;
              w_hit_deliver    = True;
            end else begin
              w_state_nxt    = ST_MISS;
              w_mem_req_nxt  = True;
              w_mem_addr_nxt = word_align(pc_i);
              w_miss_pc_nxt  = pc_i;
            end
          end
        end
        ST_MISS: begin
          if (mem_done) begin
            w_fill           = True;
            w_pc_o_nxt       = r_miss_pc;
            w_inst_o_nxt     = mem_inst;
            w_inst_valid_nxt = True;
            w_mem_req_nxt    = False;
            w_state_nxt      = ST_IDLE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_pc_o       <= ZERO_WORD;
      r_inst_o     <= ZERO_WORD;
      r_inst_valid <= False;
      r_mem_addr   <= ZERO_WORD;
      r_mem_req    <= False;
      r_miss_pc    <= ZERO_WORD;
    end else if (rdy) begin
      r_state      <= w_state_nxt;
      r_pc_o       <= w_pc_o_nxt;
      r_inst_o     <= w_inst_o_nxt;
      r_inst_valid <= w_inst_valid_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_req    <= w_mem_req_nxt;
      r_miss_pc    <= w_miss_pc_nxt;
    end
  end

  assign if_stall   = (r_state == ST_MISS) || (pc_valid && !w_hit && !jump_or_not);
  assign pc_o       = r_pc_o;
  assign inst_o     = r_inst_o;
  assign inst_valid = r_inst_valid;
  assign mem_addr   = r_mem_addr;
  assign mem_req    = r_mem_req;

`ifdef IFETCH_ICACHE_PERF_EN
  logic        w_miss_start;
  logic [31:0] r_hit_cnt, r_miss_cnt;

  assign w_miss_start = (r_state == ST_IDLE) && pc_valid && !w_hit && !jump_or_not;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (rdy) begin
      if (w_hit_deliver) r_hit_cnt  <= r_hit_cnt + 32'd1;
      if (w_miss_start)  r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`endif

endmodule

// File: tb/tb_ifetch_icache.sv
// Scoreboard bench for ifetch_icache: one WAYS=1 and one WAYS=2 instance driven
// by directed fetch sequences; a monitor checks every delivered instruction.
module tb_ifetch_icache;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        rdy        [2];
  logic [31:0] pc_i       [2];
  logic        pc_valid   [2];
  logic        jump       [2];
  logic [31:0] mem_inst   [2];
  logic        mem_done   [2];
  logic [31:0] pc_o       [2];
  logic [31:0] inst_o     [2];
  logic        inst_valid [2];
  logic        if_stall   [2];
  logic [31:0] mem_addr   [2];
  logic        mem_req    [2];
`ifdef IFETCH_ICACHE_PERF_EN
  logic [31:0] hit_cnt    [2];
  logic [31:0] miss_cnt   [2];
`endif

  ifetch_icache #(.INDEX_BITS(8), .TAG_BITS(8), .WAYS(1)) u_dut_dm (
    .clk(clk), .rst(rst), .rdy(rdy[0]), .pc_i(pc_i[0]), .pc_valid(pc_valid[0]),
    .jump_or_not(jump[0]), .pc_o(pc_o[0]), .inst_o(inst_o[0]), .inst_valid(inst_valid[0]),
    .if_stall(if_stall[0]), .mem_addr(mem_addr[0]), .mem_req(mem_req[0]),
    .mem_inst(mem_inst[0]), .mem_done(mem_done[0])
`ifdef IFETCH_ICACHE_PERF_EN
    , .hit_cnt(hit_cnt[0]), .miss_cnt(miss_cnt[0])
`endif
  );

  ifetch_icache #(.INDEX_BITS(8), .TAG_BITS(8), .WAYS(2)) u_dut_2w (
    .clk(clk), .rst(rst), .rdy(rdy[1]), .pc_i(pc_i[1]), .pc_valid(pc_valid[1]),
    .jump_or_not(jump[1]), .pc_o(pc_o[1]), .inst_o(inst_o[1]), .inst_valid(inst_valid[1]),
    .if_stall(if_stall[1]), .mem_addr(mem_addr[1]), .mem_req(mem_req[1]),
    .mem_inst(mem_inst[1]), .mem_done(mem_done[1])
`ifdef IFETCH_ICACHE_PERF_EN
    , .hit_cnt(hit_cnt[1]), .miss_cnt(miss_cnt[1])
`endif
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t exp_q0[$];
  exp_t exp_q1[$];
  exp_t m_e;
  int   n_vec = 0;
  int   n_err = 0;
  int   hits[2];
  int   misses[2];

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[23:0], 8'h13};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push(input int d, input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.inst = mem_data(pc);
    if (d == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (inst_valid[0]) begin
        if (exp_q0.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_valid dut0: got pc_o=%h want no delivery", pc_o[0]);
        end else begin
          m_e = exp_q0.pop_front();
          check("deliver pc_o dut0", pc_o[0], m_e.pc);
          check("deliver inst_o dut0", inst_o[0], m_e.inst);
        end
      end
      if (inst_valid[1]) begin
        if (exp_q1.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_valid dut1: got pc_o=%h want no delivery", pc_o[1]);
        end else begin
          m_e = exp_q1.pop_front();
          check("deliver pc_o dut1", pc_o[1], m_e.pc);
          check("deliver inst_o dut1", inst_o[1], m_e.inst);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_hit(input int d, input logic [31:0] pc);
    pc_i[d] = pc; pc_valid[d] = 1'b1;
    #1;
    check("hit if_stall", if_stall[d], 0);
    push(d, pc); hits[d]++;
    tick();
    pc_valid[d] = 1'b0;
    check("hit inst_valid", inst_valid[d], 1);
    check("hit mem_req", mem_req[d], 0);
  endtask

  // mode: 0 plain refill, 1 flush before mem_done, 2 flush with mem_done, 3 rdy stall
  task automatic fetch_miss(input int d, input logic [31:0] pc, input int mode);
    pc_i[d] = pc; pc_valid[d] = 1'b1;
    #1;
    check("miss if_stall", if_stall[d], 1);
    misses[d]++;
    tick();
    pc_valid[d] = 1'b0; pc_i[d] = 32'hDEAD_BEEC;
    check("miss mem_req", mem_req[d], 1);
    check("miss mem_addr", mem_addr[d], {pc[31:2], 2'b00});
    check("miss if_stall held", if_stall[d], 1);
    if (mode == 3) begin
      rdy[d] = 1'b0;
      repeat (3) begin
        tick();
        check("rdy0 mem_req", mem_req[d], 1);
        check("rdy0 mem_addr", mem_addr[d], {pc[31:2], 2'b00});
      end
      rdy[d] = 1'b1;
    end else begin
      tick();
    end
    if (mode == 1) begin
      jump[d] = 1'b1;
      tick();
      jump[d] = 1'b0;
      check("flush mem_req", mem_req[d], 0);
      check("flush inst_valid", inst_valid[d], 0);
      check("flush if_stall", if_stall[d], 0);
    end else begin
      mem_inst[d] = mem_data(pc); mem_done[d] = 1'b1;
      if (mode == 2) jump[d] = 1'b1;
      else           push(d, pc);
      tick();
      mem_done[d] = 1'b0; jump[d] = 1'b0; mem_inst[d] = 32'h0;
      check("refill mem_req", mem_req[d], 0);
      check("refill inst_valid", inst_valid[d], (mode == 2) ? 0 : 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      rdy[d] = 1'b1; pc_i[d] = '0; pc_valid[d] = 1'b0; jump[d] = 1'b0;
      mem_inst[d] = '0; mem_done[d] = 1'b0; hits[d] = 0; misses[d] = 0;
    end
    tick(); tick();
    for (int d = 0; d < 2; d++) begin
      check("rst pc_o", pc_o[d], 0);
      check("rst inst_o", inst_o[d], 0);
      check("rst inst_valid", inst_valid[d], 0);
      check("rst if_stall", if_stall[d], 0);
      check("rst mem_req", mem_req[d], 0);
      check("rst mem_addr", mem_addr[d], 0);
    end
    rst = 1'b0;
    tick();

    // Direct-mapped: conflicting tag evicts the line.
    fetch_miss(0, 32'h0000, 0);
    fetch_hit (0, 32'h0000);
    fetch_miss(0, 32'h0400, 0);
    fetch_miss(0, 32'h0000, 0);

    // 2-way: both lines coexist; LRU evicts the untouched one.
    fetch_miss(1, 32'h0000, 0);
    fetch_hit (1, 32'h0000);
    fetch_miss(1, 32'h0400, 0);
    fetch_hit (1, 32'h0000);
    fetch_miss(1, 32'h0800, 0);
    fetch_hit (1, 32'h0000);
    fetch_hit (1, 32'h0800);
    fetch_miss(1, 32'h0400, 0);
    fetch_hit (1, 32'h0800);

    // Flush without fill, then flush coinciding with fill.
    fetch_miss(0, 32'h0010, 1);
    fetch_miss(0, 32'h0010, 2);
    fetch_hit (0, 32'h0010);

    // Global stall in the middle of a refill.
    fetch_miss(0, 32'h0044, 3);
    fetch_hit (0, 32'h0044);

    // Back-to-back hits, one per cycle.
    foreach (exp_q0[i]) begin end
    pc_valid[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      pc_i[0] = (k == 0) ? 32'h0000 : (k == 1) ? 32'h0010 : 32'h0044;
      #1;
      check("b2b if_stall", if_stall[0], 0);
      push(0, pc_i[0]); hits[0]++;
      tick();
      check("b2b inst_valid", inst_valid[0], 1);
    end
    pc_valid[0] = 1'b0;
    tick(); tick();

    n_vec++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      n_err++;
      $display("FAIL pending_deliveries: got %0d/%0d outstanding want 0/0", exp_q0.size(), exp_q1.size());
    end
`ifdef IFETCH_ICACHE_PERF_EN
    for (int d = 0; d < 2; d++) begin
      check("perf hit_cnt", hit_cnt[d], hits[d]);
      check("perf miss_cnt", miss_cnt[d], misses[d]);
    end
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ifetch_icache.md
Name: ifetch_icache

Overview:
- Parametrised successor to the single-word instruction fetch stage.
- Sits between pc_reg and if_id; owns a configurable direct-mapped or 2-way set-associative instruction cache in front of the memory controller's fetch port.
- Replaces the combinational fetch with a clocked FSM: registered outputs, explicit miss/refill handshake, flush on jump.

Parameters:
- INDEX_BITS, 8, sets = 2**INDEX_BITS; index = pc[INDEX_BITS+1:2].
- TAG_BITS, 8, tag = pc[INDEX_BITS+2 +: TAG_BITS]; upper pc bits ignored.
- WAYS, 1, associativity; legal values 1 or 2; anything else is an elaboration error.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- rdy  in  1  global ready; when low, all state and outputs hold.
- pc_i  in  32  fetch address from pc_reg.
- pc_valid  in  1  pc_i is valid this cycle (pc_reg_rdy).
- jump_or_not  in  1  flush: branch/jump redirect.
- pc_o  out  32  pc of delivered instruction.
- inst_o  out  32  delivered instruction.
- inst_valid  out  1  one-cycle pulse; pc_o/inst_o valid.
- if_stall  out  1  fetch cannot accept a new pc.
- mem_addr  out  32  refill address.
- mem_req  out  1  refill request, level-held.
- mem_inst  in  32  refill data.
- mem_done  in  1  one-cycle pulse; mem_inst valid.

Behaviour:
- Reset: all valid bits and LRU bits cleared in one cycle; state=IDLE; pc_o=0, inst_o=0, inst_valid=0, if_stall=0, mem_addr=0, mem_req=0.
- rdy=0: no register changes; mem_req and mem_addr hold their values.
- States: IDLE, MISS.
- IDLE, pc_valid=1, hit (valid && tag match in any way):
  - Next cycle: pc_o=pc_i, inst_o=cached word, inst_valid=1.
  - For WAYS=2, the LRU bit of the set points to the other way.
  - if_stall=0.
- IDLE, pc_valid=1, miss:
  - if_stall=1 combinationally in the same cycle.
  - Next cycle: state=MISS, mem_req=1, mem_addr={pc_i[31:2],2'b00}; pc latched internally.
- MISS: if_stall=1; mem_req and mem_addr held stable until mem_done.
- MISS, mem_done=1:
  - Victim selection for WAYS=2: an invalid way first (way0 if both invalid), else the LRU way. WAYS=1: the single way.
  - Victim is written with tag and data, valid set; LRU updated.
  - Next cycle: pc_o=latched pc, inst_o=mem_inst, inst_valid=1, mem_req=0, state=IDLE.
- inst_valid is 0 in every cycle not listed above.
- jump_or_not=1 (priority over everything except rst):
  - Next cycle: state=IDLE, mem_req=0, inst_valid=0, if_stall=0.
  - pc_valid in the same cycle is ignored.
  - If mem_done coincides with the flush, the line is still filled but nothing is delivered.
  - Cache contents are never invalidated by a flush.
- Back-to-back hits: one instruction per cycle while pc_valid stays high.
- Hit-under-miss is not supported; pc_valid is ignored in MISS.
- Cache arrays are not reset; only the valid bits are.

Optional Feature:
- Macro: IFETCH_ICACHE_PERF_EN.
- Defined:
  - Adds outputs hit_cnt[31:0] and miss_cnt[31:0].
  - hit_cnt increments on each hit delivery; miss_cnt increments on each IDLE->MISS transition.
  - Both counters are cleared by rst and wrap at 2**32.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- config.v holds AddrLen, InstLen, ZERO_WORD, True/False and the new defaults ICACHE_INDEX_BITS / ICACHE_TAG_BITS.
- State encodings are localparams.
- One natural sub-module: icache_way (tag/data/valid arrays, read port plus write port), instantiated WAYS times.
- The FSM, LRU and victim logic stay in the top.

Test Plan:
- Reset, then pc_valid with pc_i=0x0000 -> if_stall=1 same cycle; next cycle mem_req=1, mem_addr=0x0000. Return mem_done with mem_inst=0x00000013 -> next cycle inst_valid=1, inst_o=0x00000013, pc_o=0.
- Re-fetch 0x0000 -> inst_valid=1 one cycle later, mem_req never asserts.
- WAYS=1: fill 0x0000, then 0x0400 (same index, different tag) -> miss; re-fetch 0x0000 -> miss again.
- WAYS=2: same sequence -> 0x0000 hits.
- WAYS=2: fill 0x0000, then 0x0400, touch 0x0000, fill 0x0800 -> 0x0400 evicted; 0x0000 still hits.
- jump_or_not during MISS for 0x0010 -> mem_req=0 next cycle, no inst_valid.
- jump_or_not coinciding with mem_done -> line is filled, so a later fetch of 0x0010 hits.
- rdy=0 for 3 cycles mid-MISS while mem_done is low -> mem_req/mem_addr unchanged. With IFETCH_ICACHE_PERF_EN, after the above sequence the hit_cnt/miss_cnt values match a scoreboard count.
